// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared constants and types for the instruction-fetch unit:
//             reset PC default, NOP encoding, FSM state encoding, BTB entry.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_OUT   = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  // Saturating 2-bit direction counter step.
  function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_btb.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_btb
//  Purpose  : Direct-mapped branch target buffer with full-PC tags and a
//             2-bit direction counter per entry. Combinational lookup,
//             registered update (an update is visible from the next cycle).
//             Only instantiated when FETCH_BTB_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int BTB_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        hit,
  output logic        taken,
  output logic [31:0] target,
  input  logic        update,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken
);

  localparam int ENTRIES = 1 << BTB_IDX_W;

  btb_entry_t           entries [ENTRIES];
  logic [BTB_IDX_W-1:0] lookup_idx;
  logic [BTB_IDX_W-1:0] update_idx;
  btb_entry_t           lookup_entry;
  btb_entry_t           update_old;
  btb_entry_t           update_new;

  // Lookup: index on word address bits, hit only on an exact PC tag match.
  always_comb begin
    lookup_idx   = lookup_pc[BTB_IDX_W+1:2];
    lookup_entry = entries[lookup_idx];
    hit          = lookup_entry.valid && (lookup_entry.tag == lookup_pc);
    taken        = hit && lookup_entry.ctr[1];
    target       = lookup_entry.target;
  end

  // Build the replacement entry: train an existing match, else allocate fresh.
  always_comb begin
    update_idx        = update_pc[BTB_IDX_W+1:2];
    update_old        = entries[update_idx];
    update_new.valid  = 1'b1;
    update_new.tag    = update_pc;
    update_new.target = update_target;
    if (update_old.valid && (update_old.tag == update_pc)) begin
      update_new.ctr = ctr_train(update_old.ctr, update_taken);
    end else begin
      update_new.ctr = update_taken ? 2'b10 : 2'b01;
    end
  end

  // Entry storage; all entries invalid out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else if (update) begin
      entries[update_idx] <= update_new;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch producer. Owns the PC, runs a single-
//             outstanding req/resp handshake with the I-cache and presents
//             one instruction at a time to decode. Execute redirects flush
//             fetch and any response still in flight is drained and dropped.
//             Define FETCH_BTB_EN to add a direct-mapped BTB predictor;
//             without it fetch always predicts PC+4.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BTB_IDX_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_core_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        icache_req_valid_o,
  input  logic        icache_req_ready_i,
  output logic [31:0] icache_req_addr_o,
  input  logic        icache_resp_valid_i,
  input  logic [31:0] icache_resp_data_i,
  input  logic        icache_resp_fault_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic [31:0] fetch_pred_pc_o,
  output logic        fetch_prediction_o,
  output logic        fetch_taken_o,
  output logic        fetch_misaligned_instr_exc_o,
  output logic        fetch_instr_fault_exc_o,
  input  logic        bp_update_i,
  input  logic [31:0] bp_update_pc_i,
  input  logic [31:0] bp_update_target_i,
  input  logic        bp_update_taken_i
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  pc;
  logic         live;            // low during and on the first edge after reset
  logic         aligned;
  logic         req_fire;
  logic         response_owed;   // a response will still arrive after this cycle
  logic         load_resp;
  logic         load_misaligned;
  logic         lookup_hit;
  logic         lookup_taken;
  logic [31:0]  lookup_target;
  logic [31:0]  pred_pc;

  assign aligned            = (pc[1:0] == 2'b00);
  assign icache_req_valid_o = (state == ST_REQ) && live && aligned;
  assign icache_req_addr_o  = icache_req_valid_o ? pc : 32'h0;
  assign req_fire           = icache_req_valid_o && icache_req_ready_i;
  assign fetch_valid_o      = (state == ST_OUT);

  // Redirecting into DRAIN only when a response is genuinely still owed;
  // a response landing in the redirect cycle itself is already consumed,
  // so waiting for another one would never end.
  assign response_owed = req_fire
                      || (((state == ST_WAIT) || (state == ST_DRAIN)) && !icache_resp_valid_i);

`ifdef FETCH_BTB_EN
  fetch_btb #(
    .BTB_IDX_W (BTB_IDX_W)
  ) u_btb (
    .clk           (clk_i),
    .rst           (rst_i),
    .lookup_pc     (pc),
    .hit           (lookup_hit),
    .taken         (lookup_taken),
    .target        (lookup_target),
    .update        (bp_update_i),
    .update_pc     (bp_update_pc_i),
    .update_target (bp_update_target_i),
    .update_taken  (bp_update_taken_i)
  );
`else
  assign lookup_hit    = 1'b0;
  assign lookup_taken  = 1'b0;
  assign lookup_target = 32'h0;

  logic unused_bp;
  assign unused_bp = &{1'b0, bp_update_i, bp_update_pc_i, bp_update_target_i,
                       bp_update_taken_i, pc[BTB_IDX_W+1:2]};
`endif

  // The prediction is captured as the instruction enters presentation so a
  // predictor update during a stall cannot disturb the held outputs.
  assign pred_pc = lookup_taken ? lookup_target : pc + 32'd4;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_REQ;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and capture decode; redirect overrides stall and response.
  always_comb begin
    state_next      = state;
    load_resp       = 1'b0;
    load_misaligned = 1'b0;
    if (redirect_i) begin
      state_next = response_owed ? ST_DRAIN : ST_REQ;
    end else begin
      case (state)
        ST_REQ: begin
          if (live) begin
            if (!aligned) begin
              load_misaligned = 1'b1;
              state_next      = ST_OUT;
            end else if (icache_req_ready_i) begin
              state_next = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (icache_resp_valid_i) begin
            load_resp  = 1'b1;
            state_next = ST_OUT;
          end
        end
        ST_OUT: begin
          if (!stall_core_i) begin
            state_next = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (icache_resp_valid_i) begin
            state_next = ST_REQ;
          end
        end
        default: state_next = ST_REQ;
      endcase
    end
  end

  // PC and presentation registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc                           <= RESET_PC;
      live                         <= 1'b0;
      fetch_instr_o                <= 32'h0;
      fetch_pc_o                   <= 32'h0;
      fetch_pred_pc_o              <= 32'h0;
      fetch_prediction_o           <= 1'b0;
      fetch_taken_o                <= 1'b0;
      fetch_misaligned_instr_exc_o <= 1'b0;
      fetch_instr_fault_exc_o      <= 1'b0;
    end else begin
      live <= 1'b1;
      if (redirect_i) begin
        pc <= redirect_pc_i;
      end else if ((state == ST_OUT) && !stall_core_i) begin
        pc <= fetch_pred_pc_o;
      end
      if (load_resp || load_misaligned) begin
        fetch_pc_o                   <= pc;
        fetch_instr_o                <= load_misaligned ? NOP_INSTR : icache_resp_data_i;
        fetch_instr_fault_exc_o      <= load_resp && icache_resp_fault_i;
        fetch_misaligned_instr_exc_o <= load_misaligned;
        fetch_pred_pc_o              <= pred_pc;
        fetch_prediction_o           <= lookup_hit;
        fetch_taken_o                <= lookup_taken;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit: directed sequences, a
//             table of redirect vectors and randomized traffic checked
//             against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_core_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        icache_req_valid_o;
  logic        icache_req_ready_i = 1'b0;
  logic [31:0] icache_req_addr_o;
  logic        icache_resp_valid_i = 1'b0;
  logic [31:0] icache_resp_data_i = 32'h0;
  logic        icache_resp_fault_i = 1'b0;
  logic        fetch_valid_o;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic [31:0] fetch_pred_pc_o;
  logic        fetch_prediction_o;
  logic        fetch_taken_o;
  logic        fetch_misaligned_instr_exc_o;
  logic        fetch_instr_fault_exc_o;
  logic        bp_update_i = 1'b0;
  logic [31:0] bp_update_pc_i = 32'h0;
  logic [31:0] bp_update_target_i = 32'h0;
  logic        bp_update_taken_i = 1'b0;

  fetch_unit #(
    .RESET_PC  (32'h0000_1000),
    .BTB_IDX_W (4)
  ) dut (
    .clk_i                        (clk),
    .rst_i                        (rst),
    .stall_core_i                 (stall_core_i),
    .redirect_i                   (redirect_i),
    .redirect_pc_i                (redirect_pc_i),
    .icache_req_valid_o           (icache_req_valid_o),
    .icache_req_ready_i           (icache_req_ready_i),
    .icache_req_addr_o            (icache_req_addr_o),
    .icache_resp_valid_i          (icache_resp_valid_i),
    .icache_resp_data_i           (icache_resp_data_i),
    .icache_resp_fault_i          (icache_resp_fault_i),
    .fetch_valid_o                (fetch_valid_o),
    .fetch_instr_o                (fetch_instr_o),
    .fetch_pc_o                   (fetch_pc_o),
    .fetch_pred_pc_o              (fetch_pred_pc_o),
    .fetch_prediction_o           (fetch_prediction_o),
    .fetch_taken_o                (fetch_taken_o),
    .fetch_misaligned_instr_exc_o (fetch_misaligned_instr_exc_o),
    .fetch_instr_fault_exc_o      (fetch_instr_fault_exc_o),
    .bp_update_i                  (bp_update_i),
    .bp_update_pc_i               (bp_update_pc_i),
    .bp_update_target_i           (bp_update_target_i),
    .bp_update_taken_i            (bp_update_taken_i)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  // I-cache responder state
  logic        pending = 1'b0;
  int          dly = 0;
  int          lat_cfg = 1;        // 0 = random latency 1..3
  logic [31:0] paddr = 32'h0;
  logic [31:0] fault_force = 32'h0000_1008;
  // reference model state
  logic [31:0] exp_pc = 32'h0000_1000;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc, prev_instr, prev_pred;
  logic [3:0]  prev_flags;
  int          btb_ctr [logic [31:0]];
  logic [31:0] btb_tgt [logic [31:0]];

  typedef struct packed {
    logic        p;
    logic        t;
    logic [31:0] npc;
  } pred_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] instr;
    logic        mis;
    logic        fault;
    logic [31:0] next_pc;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic cache_fault(input logic [31:0] a);
    return (a[6:2] == 5'd13) || (a == fault_force);
  endfunction

  function automatic pred_t model_pred(input logic [31:0] a);
    pred_t r;
    r.p   = 1'b0;
    r.t   = 1'b0;
    r.npc = a + 32'd4;
    if (btb_ctr.exists(a)) begin
      r.p = 1'b1;
      r.t = (btb_ctr[a] >= 2);
      if (r.t) r.npc = btb_tgt[a];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: serve the I-cache, run the reference model, advance.
  task automatic step();
    logic  hs;
    logic  acc;
    pred_t pr;
    icache_resp_valid_i = 1'b0;
    icache_resp_data_i  = 32'h0;
    icache_resp_fault_i = 1'b0;
    if (pending) begin
      if (dly <= 1) begin
        icache_resp_valid_i = 1'b1;
        icache_resp_data_i  = mem_word(paddr);
        icache_resp_fault_i = cache_fault(paddr);
        pending             = 1'b0;
      end else begin
        dly = dly - 1;
      end
    end
    #1;
    if (prev_hold) begin
      chk("hold_valid", {31'b0, fetch_valid_o}, 32'd1);
      chk("hold_pc", fetch_pc_o, prev_pc);
      chk("hold_instr", fetch_instr_o, prev_instr);
      chk("hold_pred_pc", fetch_pred_pc_o, prev_pred);
      chk("hold_flags", {28'b0, fetch_prediction_o, fetch_taken_o,
          fetch_misaligned_instr_exc_o, fetch_instr_fault_exc_o}, {28'b0, prev_flags});
    end
    if (fetch_valid_o) chk("no_req_while_presenting", {31'b0, icache_req_valid_o}, 32'd0);
    hs = icache_req_valid_o && icache_req_ready_i;
    if (hs) begin
      chk("one_outstanding", {30'b0, pending, icache_resp_valid_i}, 32'd0);
      chk("req_addr", icache_req_addr_o, exp_pc);
      pending = 1'b1;
      paddr   = icache_req_addr_o;
      dly     = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
    end
    acc = fetch_valid_o && !stall_core_i && !redirect_i;
    if (acc) begin
      pr = model_pred(exp_pc);
      chk("pres_pc", fetch_pc_o, exp_pc);
      if (exp_pc[1:0] != 2'b00) begin
        chk("pres_instr", fetch_instr_o, NOP_INSTR);
        chk("pres_exc", {30'b0, fetch_misaligned_instr_exc_o, fetch_instr_fault_exc_o}, 32'd2);
      end else begin
        chk("pres_instr", fetch_instr_o, mem_word(exp_pc));
        chk("pres_exc", {30'b0, fetch_misaligned_instr_exc_o, fetch_instr_fault_exc_o},
            {31'b0, cache_fault(exp_pc)});
      end
      chk("pres_pred_pc", fetch_pred_pc_o, pr.npc);
      chk("pres_pred_flags", {30'b0, fetch_prediction_o, fetch_taken_o}, {30'b0, pr.p, pr.t});
      exp_pc = pr.npc;
      acc_cnt++;
    end
    if (redirect_i) exp_pc = redirect_pc_i;
    prev_hold  = fetch_valid_o && stall_core_i && !redirect_i;
    prev_pc    = fetch_pc_o;
    prev_instr = fetch_instr_o;
    prev_pred  = fetch_pred_pc_o;
    prev_flags = {fetch_prediction_o, fetch_taken_o, fetch_misaligned_instr_exc_o,
                  fetch_instr_fault_exc_o};
`ifdef FETCH_BTB_EN
    if (bp_update_i) begin
      if (btb_ctr.exists(bp_update_pc_i)) begin
        if (bp_update_taken_i) btb_ctr[bp_update_pc_i] = (btb_ctr[bp_update_pc_i] == 3) ? 3 : btb_ctr[bp_update_pc_i] + 1;
        else                   btb_ctr[bp_update_pc_i] = (btb_ctr[bp_update_pc_i] == 0) ? 0 : btb_ctr[bp_update_pc_i] - 1;
      end else begin
        btb_ctr[bp_update_pc_i] = bp_update_taken_i ? 2 : 1;
      end
      btb_tgt[bp_update_pc_i] = bp_update_target_i;
    end
`endif
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(input string name, input int max);
    int n = 0;
    while (!fetch_valid_o && n < max) begin
      step();
      n++;
    end
    chk(name, {31'b0, fetch_valid_o}, 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    step();
    redirect_i    = 1'b0;
  endtask

  initial begin
    int          hs_c [$];
    logic [31:0] hs_a [$];
    int          v_c  [$];
    int          n;

    vecs[0] = '{32'h0000_2002, NOP_INSTR,                1'b1, 1'b0, 32'h0000_2006};
    vecs[1] = '{32'h0000_1008, mem_word(32'h0000_1008), 1'b0, 1'b1, 32'h0000_100C};
    vecs[2] = '{32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b0, 1'b0, 32'h0000_0000};
    vecs[3] = '{32'h0000_3001, NOP_INSTR,                1'b1, 1'b0, 32'h0000_3005};
    vecs[4] = '{32'h0000_4000, mem_word(32'h0000_4000), 1'b0, 1'b0, 32'h0000_4004};

    // ---- reset: every output low ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", {31'b0, icache_req_valid_o}, 32'd0);
    chk("rst_req_addr", icache_req_addr_o, 32'd0);
    chk("rst_fetch_valid", {31'b0, fetch_valid_o}, 32'd0);
    chk("rst_instr", fetch_instr_o, 32'd0);
    chk("rst_pc", fetch_pc_o, 32'd0);
    chk("rst_pred_pc", fetch_pred_pc_o, 32'd0);
    chk("rst_flags", {28'b0, fetch_prediction_o, fetch_taken_o,
        fetch_misaligned_instr_exc_o, fetch_instr_fault_exc_o}, 32'd0);
    rst = 1'b0;
    cyc = 0;

    // ---- throughput: ready=1, 1-cycle latency ----
    icache_req_ready_i = 1'b1;
    lat_cfg = 1;
    for (int i = 0; i < 10; i++) begin
      if (icache_req_valid_o && icache_req_ready_i) begin
        hs_c.push_back(cyc);
        hs_a.push_back(icache_req_addr_o);
      end
      if (fetch_valid_o) v_c.push_back(cyc);
      step();
    end
    chk("thr_req_count", hs_c.size(), 32'd3);
    chk("thr_valid_count", v_c.size(), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < hs_c.size()) begin
        chk("thr_req_addr", hs_a[k], 32'h0000_1000 + 32'(4 * k));
        chk("thr_req_cycle", hs_c[k], 32'(1 + 3 * k));
      end
      if (k < v_c.size()) chk("thr_valid_cycle", v_c[k], 32'(3 + 3 * k));
    end

    // ---- stall holds the presented instruction for 5 cycles ----
    stall_core_i = 1'b1;
    wait_valid("stall_valid_timeout", 10);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, fetch_valid_o}, 32'd1);
      chk("stall_pc", fetch_pc_o, 32'h0000_100C);
      chk("stall_no_req", {31'b0, icache_req_valid_o}, 32'd0);
      step();
    end
    stall_core_i = 1'b0;
    step();

    // ---- redirect while waiting; stale response must be dropped ----
    lat_cfg = 3;
    n = 0;
    while (!(icache_req_valid_o && icache_req_ready_i) && n < 10) begin
      step();
      n++;
    end
    chk("drain_req_seen", {31'b0, icache_req_valid_o}, 32'd1);
    step();
    do_redirect(32'h0000_2000);
    for (int i = 0; i < 2; i++) begin
      chk("drain_no_valid", {31'b0, fetch_valid_o}, 32'd0);
      step();
    end
    lat_cfg = 1;
    stall_core_i = 1'b1;
    wait_valid("drain_valid_timeout", 10);
    chk("drain_pc", fetch_pc_o, 32'h0000_2000);
    chk("drain_instr", fetch_instr_o, mem_word(32'h0000_2000));
    stall_core_i = 1'b0;
    step();

    // ---- table: redirect targets, exceptions, wrap ----
    for (int i = 0; i < 5; i++) begin
      stall_core_i = 1'b1;
      do_redirect(vecs[i].rpc);
      wait_valid("vec_valid_timeout", 20);
      chk("vec_pc", fetch_pc_o, vecs[i].rpc);
      chk("vec_instr", fetch_instr_o, vecs[i].instr);
      chk("vec_misaligned", {31'b0, fetch_misaligned_instr_exc_o}, {31'b0, vecs[i].mis});
      chk("vec_fault", {31'b0, fetch_instr_fault_exc_o}, {31'b0, vecs[i].fault});
      chk("vec_pred_pc", fetch_pred_pc_o, vecs[i].next_pc);
      stall_core_i = 1'b0;
      step();
      stall_core_i = 1'b1;
      wait_valid("vec_next_timeout", 20);
      chk("vec_next_pc", fetch_pc_o, vecs[i].next_pc);
      stall_core_i = 1'b0;
      step();
    end

`ifdef FETCH_BTB_EN
    // ---- BTB: two taken trainings, then predicted redirect of flow ----
    bp_update_i        = 1'b1;
    bp_update_pc_i     = 32'h0000_1004;
    bp_update_target_i = 32'h0000_3000;
    bp_update_taken_i  = 1'b1;
    step();
    step();
    bp_update_i = 1'b0;
    stall_core_i = 1'b1;
    do_redirect(32'h0000_1004);
    wait_valid("btb_valid_timeout", 20);
    chk("btb_prediction", {31'b0, fetch_prediction_o}, 32'd1);
    chk("btb_taken", {31'b0, fetch_taken_o}, 32'd1);
    chk("btb_pred_pc", fetch_pred_pc_o, 32'h0000_3000);
    stall_core_i = 1'b0;
    step();
    stall_core_i = 1'b1;
    wait_valid("btb_next_timeout", 20);
    chk("btb_next_pc", fetch_pc_o, 32'h0000_3000);
    stall_core_i = 1'b0;
    step();
`endif

    // ---- randomized traffic against the reference model ----
    lat_cfg = 0;
    acc_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      stall_core_i       = ($urandom % 4) == 0;
      icache_req_ready_i = ($urandom % 4) != 0;
      redirect_i         = ($urandom % 40) == 0;
      case ($urandom % 8)
        0:       redirect_pc_i = $urandom | 32'h1;
        1:       redirect_pc_i = 32'hFFFF_FFF8;
        default: redirect_pc_i = 32'h0000_2000 + ($urandom % 64) * 4;
      endcase
      step();
    end
    redirect_i   = 1'b0;
    stall_core_i = 1'b0;
    chk("random_progress", {31'b0, acc_cnt > 200}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
